// File: rtl/seed_leaf_dispenser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seed_leaf_dispenser_pkg
//  Description : Shared Picnic constants and the dispenser state encoding.
//                SEED_W   - width of the concatenated seed-tree output
//                LEAF_W   - width of one leaf seed
//                N_LEAVES - leaves per batch
//                IDX_W    - leaf index width
//  Revision    : 1.0 - initial release
// ============================================================================
package seed_leaf_dispenser_pkg;

    localparam int SEED_W   = 4096;
    localparam int LEAF_W   = 256;
    localparam int N_LEAVES = 16;
    localparam int IDX_W    = 4;

    // log2(LEAF_W): a leaf's bit offset is its reversed index shifted by this.
    localparam int LEAF_SH  = $clog2(LEAF_W);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LEAVES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage : seed_leaf_dispenser_pkg
`default_nettype wire

// File: rtl/seed_leaf_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : seed_leaf_dispenser
//  Description : Captures the eight concatenated 512-bit seed-tree hashes and
//                hands them out as sixteen 256-bit leaf seeds on a
//                valid/ready stream, optionally withholding one leaf.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous reset, active low
//                seed_in    - 4096-bit seed, leaf 0 in the top 256 bits
//                seed_load  - one-cycle pulse, seed_in valid
//                skip_en    - withhold leaf skip_idx from the batch
//                skip_idx   - index of the withheld leaf
//                out_ready  - downstream accepts the current leaf
//                leaf_seed  - current leaf seed
//                leaf_idx   - index of the current leaf
//                leaf_valid - leaf_seed/leaf_idx valid
//                leaf_last  - current leaf is the last of the batch
//                busy       - batch in progress
//                done       - one-cycle pulse after the last leaf transfer
//                overrun    - sticky: seed_load arrived mid-batch
//  Revision    : 1.0 - initial release
// ============================================================================
module seed_leaf_dispenser
    import seed_leaf_dispenser_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [SEED_W-1:0] seed_in,
    input  logic              seed_load,
    input  logic              skip_en,
    input  logic [IDX_W-1:0]  skip_idx,
    input  logic              out_ready,
    output logic [LEAF_W-1:0] leaf_seed,
    output logic [IDX_W-1:0]  leaf_idx,
    output logic              leaf_valid,
    output logic              leaf_last,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    state_e             state_q,      state_d;
    logic [SEED_W-1:0]  seed_q,       seed_d;
    logic               skip_en_q,    skip_en_d;
    logic [IDX_W-1:0]   skip_idx_q,   skip_idx_d;
    logic [LEAF_W-1:0]  leaf_seed_q,  leaf_seed_d;
    logic [IDX_W-1:0]   leaf_idx_q,   leaf_idx_d;
    logic               leaf_valid_q, leaf_valid_d;
    logic               leaf_last_q,  leaf_last_d;
    logic               done_q,       done_d;
    logic               overrun_q,    overrun_d;

    logic               xfer;
    logic               capture;
    logic [IDX_W-1:0]   first_idx;
    logic [IDX_W-1:0]   next_idx;
    logic [SEED_W-1:0]  sel_seed;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_skip_en;
    logic [IDX_W-1:0]   sel_skip_idx;
    logic [LEAF_W-1:0]  sel_leaf;
    logic               sel_last;

    always_comb begin
        xfer    = leaf_valid_q & out_ready;
        // A load is taken in IDLE, or in SEND exactly when the last leaf
        // leaves this cycle, so back-to-back batches need no idle gap.
        capture = seed_load & ((state_q == ST_IDLE) | (xfer & leaf_last_q));

        first_idx = (skip_en && (skip_idx == '0)) ? IDX_W'(1) : '0;

        next_idx = leaf_idx_q + IDX_W'(1);
        if (skip_en_q && (next_idx == skip_idx_q)) begin
            next_idx = next_idx + IDX_W'(1);
        end

        // A new batch is presented straight from the inputs, since the
        // capture registers only update at the same edge.
        sel_seed     = capture ? seed_in   : seed_q;
        sel_idx      = capture ? first_idx : next_idx;
        sel_skip_en  = capture ? skip_en   : skip_en_q;
        sel_skip_idx = capture ? skip_idx  : skip_idx_q;

        // Leaf k sits at bit offset (15-k)*256; ~k == 15-k for 4-bit k.
        sel_leaf = sel_seed[{~sel_idx, {LEAF_SH{1'b0}}} +: LEAF_W];
        sel_last = (sel_idx == LAST_IDX) ||
                   (sel_skip_en && (sel_skip_idx == LAST_IDX) &&
                    (sel_idx == LAST_IDX - IDX_W'(1)));

        state_d      = state_q;
        seed_d       = seed_q;
        skip_en_d    = skip_en_q;
        skip_idx_d   = skip_idx_q;
        leaf_seed_d  = leaf_seed_q;
        leaf_idx_d   = leaf_idx_q;
        leaf_valid_d = leaf_valid_q;
        leaf_last_d  = leaf_last_q;
        done_d       = xfer & leaf_last_q;
        overrun_d    = overrun_q | (seed_load & (state_q == ST_SEND) & ~capture);

        if (capture) begin
            state_d      = ST_SEND;
            seed_d       = seed_in;
            skip_en_d    = skip_en;
            skip_idx_d   = skip_idx;
            leaf_seed_d  = sel_leaf;
            leaf_idx_d   = sel_idx;
            leaf_valid_d = 1'b1;
            leaf_last_d  = sel_last;
        end else if (xfer) begin
            if (leaf_last_q) begin
                state_d      = ST_IDLE;
                leaf_valid_d = 1'b0;
                leaf_last_d  = 1'b0;
            end else begin
                leaf_seed_d  = sel_leaf;
                leaf_idx_d   = sel_idx;
                leaf_last_d  = sel_last;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            seed_q       <= '0;
            skip_en_q    <= 1'b0;
            skip_idx_q   <= '0;
            leaf_seed_q  <= '0;
            leaf_idx_q   <= '0;
            leaf_valid_q <= 1'b0;
            leaf_last_q  <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            seed_q       <= seed_d;
            skip_en_q    <= skip_en_d;
            skip_idx_q   <= skip_idx_d;
            leaf_seed_q  <= leaf_seed_d;
            leaf_idx_q   <= leaf_idx_d;
            leaf_valid_q <= leaf_valid_d;
            leaf_last_q  <= leaf_last_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign leaf_seed  = leaf_seed_q;
    assign leaf_idx   = leaf_idx_q;
    assign leaf_valid = leaf_valid_q;
    assign leaf_last  = leaf_last_q;
    assign busy       = (state_q == ST_SEND);
    assign done       = done_q;
    assign overrun    = overrun_q;

endmodule : seed_leaf_dispenser
`default_nettype wire

// File: doc/seed_leaf_dispenser.md
SEED_LEAF_DISPENSER -- requirements
Module: seed_leaf_dispenser

Interface
REQ-001 SHALL have clock clk, a 1-bit rising-edge input.
REQ-002 SHALL have reset reset, asynchronous, active-low, a 1-bit input.
REQ-003 SHALL have port seed_in, input, 4096 bits: the eight concatenated 512-bit hash outputs from the seed tree.
REQ-004 SHALL have port seed_load, input, 1 bit: one-cycle pulse, driven by the seed tree's tree_set_end, meaning seed_in is valid.
REQ-005 SHALL have port skip_en, input, 1 bit: when set, one leaf is withheld (the hidden party).
REQ-006 SHALL have port skip_idx, input, 4 bits: index of the withheld leaf, sampled together with seed_load.
REQ-007 SHALL have port out_ready, input, 1 bit: downstream accepts the current leaf.
REQ-008 SHALL have port leaf_seed, output, 256 bits: the current leaf seed.
REQ-009 SHALL have port leaf_idx, output, 4 bits: index of leaf_seed.
REQ-010 SHALL have port leaf_valid, output, 1 bit: leaf_seed and leaf_idx are valid.
REQ-011 SHALL have port leaf_last, output, 1 bit: the current leaf is the final one of the batch.
REQ-012 SHALL have port busy, output, 1 bit: a batch is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a batch completes.
REQ-014 SHALL have port overrun, output, 1 bit: sticky error flag.

Function
REQ-015 SHALL define leaf k (k = 0..15) as seed_in[4095-256k : 3840-256k], so leaf 0 is seed_in[4095:3840].
REQ-016 SHALL implement two states: IDLE and SEND.
- IDLE: seed_load=1 captures seed_in, skip_en and skip_idx into internal registers and moves to SEND.
- Nothing else leaves IDLE.
REQ-017 SHALL assert leaf_valid from the cycle after capture, presenting the lowest non-skipped index first (index 1 when skip_en=1 and skip_idx=0, otherwise index 0).
REQ-018 SHALL count a transfer as any cycle with leaf_valid=1 and out_ready=1. On a transfer, the next cycle presents the next higher non-skipped index.
REQ-019 SHALL hold leaf_seed, leaf_idx and leaf_last stable while leaf_valid=1 and out_ready=0.
REQ-020 SHALL assert leaf_last on leaf 15, or on leaf 14 when skip_en=1 and skip_idx=15.
REQ-021 SHALL emit 16 leaves per batch when skip_en=0, and 15 when skip_en=1. The skipped index SHALL never appear on leaf_idx.
REQ-022 SHALL, on the transfer of the last leaf, return to IDLE, deassert leaf_valid, and pulse done for exactly the following cycle.
REQ-023 SHALL assert busy in SEND, and SHALL deassert it in IDLE.
REQ-024 SHALL accept a seed_load that coincides with the last-leaf transfer:
- captures the new batch;
- stays in SEND with leaf_valid=1 on the new first leaf;
- still pulses done.
REQ-025 SHALL ignore seed_load in SEND other than the case in REQ-024, leaving the captured data unchanged, and SHALL set overrun=1. overrun SHALL stay at 1 until reset.
REQ-026 SHALL use out_ready only while leaf_valid=1; out_ready SHALL have no effect in IDLE.
REQ-027 SHALL drive leaf_seed, leaf_idx and leaf_last from registers, with no combinational path from inputs to outputs except none. Zero combinational paths.

Reset
REQ-028 SHALL, on reset low, immediately force the following, independent of clk and including mid-batch:
- state = IDLE;
- leaf_valid = 0, leaf_last = 0, busy = 0, done = 0, overrun = 0;
- leaf_idx = 0, leaf_seed = 0;
- captured seed = 0.
REQ-029 SHALL not emit a done pulse for a batch aborted by reset.

Structure
REQ-030 SHALL place the following in the shared Picnic package:
- constants SEED_W=4096, LEAF_W=256, N_LEAVES=16, IDX_W=4;
- the state encoding IDLE/SEND.
REQ-031 SHALL be a single module with no sub-modules. The 16:1 leaf select and the next-non-skipped-index logic SHALL be inline.

Verification
REQ-032 Test no-skip batch with out_ready=1 held high:
- stimulus: seed_in with leaf k = {32{8'h(k)}}, skip_en=0, seed_load pulse;
- required: 16 consecutive transfers with idx 0..15 and matching data;
- required: leaf_last only on idx 15;
- required: done pulsed 1 cycle after the idx-15 transfer.
REQ-033 Test skip_en=1, skip_idx=0, then a separate batch with skip_en=1, skip_idx=15:
- skip_idx=0 required: idx 1..15 and 15 transfers;
- skip_idx=15 required: idx 0..14 with leaf_last on 14.
REQ-034 Test backpressure: out_ready toggled 1,0,0,1,... -> leaf_seed and leaf_idx unchanged during every out_ready=0 cycle, and no index lost or duplicated.
REQ-035 Test seed_load re-asserted at the 3rd leaf of a batch:
- required: overrun=1 and staying 1;
- required: the batch completes with the original data.
REQ-036 Test seed_load coincident with the final transfer:
- required: done pulse;
- required: leaf_valid stays 1;
- required: the next leaf is idx 0 of the new seed.
REQ-037 Test reset low during leaf 7:
- required: all outputs 0 at once;
- required: no done pulse;
- required: a subsequent seed_load runs a complete 16-leaf batch.
